// File: rtl/prores_vlc_pkg.sv
// Shared ProRes VLC definitions: decoder FSM states and the AC level codebook
// lookup used by both the AC level encoder and decoder.
package prores_vlc_pkg;

  typedef enum logic [2:0] {
    ST_RICE    = 3'd0,
    ST_EXP_PRE = 3'd1,
    ST_EXP_SUF = 3'd2,
    ST_SIGN    = 3'd3,
    ST_ERR     = 3'd4
  } ac_level_state_t;

  typedef struct packed {
    logic [1:0] l;
    logic [1:0] k;
  } ac_level_cb_t;

  // Rice prefix length l and exp-Golomb order k selected by the previous
  // abs_level_minus_1; only the classes 0,1,2,3,4..7,>=8 are distinct.
  function automatic ac_level_cb_t ac_level_codebook(input logic [3:0] prev);
    ac_level_cb_t cb;
    if (prev == 4'd0)      cb = '{l: 2'd3, k: 2'd2};
    else if (prev == 4'd1) cb = '{l: 2'd2, k: 2'd1};
    else if (prev == 4'd2) cb = '{l: 2'd3, k: 2'd1};
    else if (prev == 4'd3) cb = '{l: 2'd0, k: 2'd0};
    else if (prev < 4'd8)  cb = '{l: 2'd0, k: 2'd1};
    else                   cb = '{l: 2'd0, k: 2'd2};
    return cb;
  endfunction

endpackage

// File: rtl/entropy_decode_ac_level_coefficients_if.sv
// Bit-in / level-out handshake bundle of the AC level decoder.
interface entropy_decode_ac_level_coefficients_if #(
  parameter int LEVEL_W = 20
) ();
  logic                      start;
  logic                      bit_valid;
  logic                      bit_in;
  logic                      bit_ready;
  logic                      level_valid;
  logic signed [LEVEL_W-1:0] level;
  logic                      level_ready;
  logic                      err;

  modport master (
    output start, bit_valid, bit_in, level_ready,
    input  bit_ready, level_valid, level, err
  );

  modport slave (
    input  start, bit_valid, bit_in, level_ready,
    output bit_ready, level_valid, level, err
  );
endinterface

// File: rtl/ac_level_codebook_sel.sv
// Combinational prev -> (l, k) codebook selection for AC level codewords.
module ac_level_codebook_sel
  import prores_vlc_pkg::*;
(
  input  logic [3:0] prev,
  output logic [1:0] l,
  output logic [1:0] k
);
  ac_level_cb_t cb;

  assign cb = ac_level_codebook(prev);
  assign l  = cb.l;
  assign k  = cb.k;
endmodule

// File: rtl/entropy_decode_ac_level_coefficients.sv
// Bit-serial ProRes AC level decoder: hybrid Rice / exp-Golomb magnitude plus
// sign, with the adaptive codebook driven by the previous magnitude.
module entropy_decode_ac_level_coefficients
  import prores_vlc_pkg::*;
#(
  parameter int LEVEL_W       = 20,
  parameter int MAX_EXP_ZEROS = 18
) (
  input logic clk,
  input logic reset_n,
  entropy_decode_ac_level_coefficients_if.slave bus
);
  // y carries up to z+k+1 significant bits, so leave headroom above the prefix limit
  localparam int ACC_W = MAX_EXP_ZEROS + 4;
  localparam int ZW    = $clog2(MAX_EXP_ZEROS + 2);
  localparam int RW    = $clog2(MAX_EXP_ZEROS + 4);

  ac_level_state_t           state_reg, state_next;
  logic [3:0]                prev_reg, prev_next;
  logic [1:0]                l_reg, k_reg, cb_l, cb_k;
  logic [1:0]                c_reg, c_next;
  logic [ZW-1:0]             z_reg, z_next;
  logic [RW-1:0]             r_reg, r_next;
  logic [ACC_W-1:0]          y_reg, y_next, y_shift;
  logic [ACC_W-1:0]          v_reg, v_next;
  logic                      level_valid_reg, level_valid_next;
  logic signed [LEVEL_W-1:0] level_reg, level_next;
  logic [LEVEL_W-1:0]        mag;
  logic                      bit_ready;
  logic                      accept;

  assign bit_ready = !bus.start && !(level_valid_reg && !bus.level_ready);
  assign accept    = bus.bit_valid && bit_ready;
  assign mag       = v_reg[LEVEL_W-1:0] + LEVEL_W'(1);

  always_comb begin
    prev_next = prev_reg;
    if (bus.start)
      prev_next = 4'd1;
    else if (accept && state_reg == ST_SIGN)
      prev_next = (v_reg > ACC_W'(15)) ? 4'd15 : v_reg[3:0];
  end

  // Looked up from prev_next so a finished codeword can pick the next entry state
  ac_level_codebook_sel u_cb_sel (
    .prev (prev_next),
    .l    (cb_l),
    .k    (cb_k)
  );

  always_comb begin
    state_next       = state_reg;
    c_next           = c_reg;
    z_next           = z_reg;
    r_next           = r_reg;
    y_next           = y_reg;
    v_next           = v_reg;
    level_next       = level_reg;
    level_valid_next = level_valid_reg;
    y_shift          = (y_reg << 1) | ACC_W'(bus.bit_in);

    if (level_valid_reg && bus.level_ready)
      level_valid_next = 1'b0;

    if (bus.start) begin
      state_next = ST_RICE;
      c_next     = '0;
      z_next     = '0;
    end else if (accept) begin
      case (state_reg)
        ST_RICE: begin
          if (bus.bit_in) begin
            v_next     = ACC_W'(c_reg);
            state_next = ST_SIGN;
          end else begin
            c_next = c_reg + 2'd1;
            if (c_reg + 2'd1 == l_reg) begin
              z_next     = '0;
              state_next = ST_EXP_PRE;
            end
          end
        end
        ST_EXP_PRE: begin
          if (bus.bit_in) begin
            y_next = ACC_W'(1);
            r_next = RW'(z_reg) + RW'(k_reg);
            if (z_reg == '0 && k_reg == 2'd0) begin
              v_next     = ACC_W'(l_reg);
              state_next = ST_SIGN;
            end else begin
              state_next = ST_EXP_SUF;
            end
          end else begin
            z_next = z_reg + ZW'(1);
            if (z_reg >= ZW'(MAX_EXP_ZEROS))
              state_next = ST_ERR;
          end
        end
        ST_EXP_SUF: begin
          y_next = y_shift;
          r_next = r_reg - RW'(1);
          if (r_reg == RW'(1)) begin
            v_next     = ACC_W'(l_reg) + y_shift - (ACC_W'(1) << k_reg);
            state_next = ST_SIGN;
          end
        end
        ST_SIGN: begin
          level_next       = bus.bit_in ? LEVEL_W'(-mag) : mag;
          level_valid_next = 1'b1;
          c_next           = '0;
          z_next           = '0;
          state_next       = (cb_l == 2'd0) ? ST_EXP_PRE : ST_RICE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_RICE;
      prev_reg        <= 4'd1;
      l_reg           <= 2'd2;
      k_reg           <= 2'd1;
      c_reg           <= '0;
      z_reg           <= '0;
      r_reg           <= '0;
      y_reg           <= '0;
      v_reg           <= '0;
      level_valid_reg <= 1'b0;
      level_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      prev_reg        <= prev_next;
      l_reg           <= cb_l;
      k_reg           <= cb_k;
      c_reg           <= c_next;
      z_reg           <= z_next;
      r_reg           <= r_next;
      y_reg           <= y_next;
      v_reg           <= v_next;
      level_valid_reg <= level_valid_next;
      level_reg       <= level_next;
    end
  end

  assign bus.bit_ready   = bit_ready;
  assign bus.level_valid = level_valid_reg;
  assign bus.level       = level_reg;
  assign bus.err         = (state_reg == ST_ERR);

endmodule

// File: tb/tb_entropy_decode_ac_level_coefficients.sv
// Directed bench for the AC level decoder: codeword table plus hand-written
// sequences for latency, stream error, backpressure, reset and start priority.
module tb_entropy_decode_ac_level_coefficients;
  localparam int LW = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  entropy_decode_ac_level_coefficients_if #(.LEVEL_W(LW)) bus ();

  entropy_decode_ac_level_coefficients #(
    .LEVEL_W       (LW),
    .MAX_EXP_ZEROS (18)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] bits;
    int          len;
    int          exp_level;
  } vec_t;

  vec_t vecs[12];
  int errors = 0;
  int checks = 0;
  logic signed [LW-1:0] got_q[$];

  always @(negedge clk)
    if (reset_n && bus.level_valid && bus.level_ready)
      got_q.push_back(bus.level);

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int waited;
    waited = 0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    @(negedge clk);
    while (!bus.bit_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.bit_ready) begin
      checks++;
      errors++;
      $display("FAIL send_bit: bit_ready stuck at 0 for %0d cycles, required 1", waited);
    end
    tick();
  endtask

  task automatic send_word(input logic [31:0] bits, input int len);
    for (int i = len - 1; i >= 0; i--) send_bit(bits[i]);
  endtask

  task automatic idle();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_levels(input int n);
    int w;
    w = 0;
    while (got_q.size() < n && w < 100) begin
      tick();
      w++;
    end
    tick();
  endtask

  function automatic longint got_at(input int i);
    return (i < got_q.size()) ? longint'(got_q[i]) : 0;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'b10,          2,   1};
    vecs[1]  = '{32'b011,         3,  -2};
    vecs[2]  = '{32'b0001010,     7,   6};
    vecs[3]  = '{32'b101,         3,  -1};
    vecs[4]  = '{32'b000010010,   9,   9};
    vecs[5]  = '{32'b1001,        4,  -1};
    vecs[6]  = '{32'b0010,        4,   3};
    vecs[7]  = '{32'b000101,      6,  -4};
    vecs[8]  = '{32'b10,          2,   1};
    vecs[9]  = '{32'b00000101011, 11, -21};
    vecs[10] = '{32'b010010,      6,   6};
    vecs[11] = '{32'b01011,       5,  -4};

    bus.start = 1'b0;
    bus.level_ready = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_level_valid", bus.level_valid, 0);
    check("rst_level", bus.level, 0);
    check("rst_err", bus.err, 0);
    check("rst_bit_ready", bus.bit_ready, 1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    tick();

    // latency: "1","0" gives level_valid exactly at cycle 2
    pulse_start();
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    @(negedge clk) check("lat_cycle0_valid", bus.level_valid, 0);
    @(posedge clk) #1 bus.bit_in = 1'b0;
    @(negedge clk) check("lat_cycle1_valid", bus.level_valid, 0);
    @(posedge clk) #1 idle();
    @(negedge clk);
    check("lat_cycle2_valid", bus.level_valid, 1);
    check("lat_cycle2_level", bus.level, 1);
    tick();
    got_q.delete();

    // table: back-to-back codewords from a fresh start
    pulse_start();
    for (int i = 0; i < 12; i++) send_word(vecs[i].bits, vecs[i].len);
    idle();
    wait_levels(12);
    check("vec_count", got_q.size(), 12);
    for (int i = 0; i < 12; i++) check($sformatf("vec%0d_level", i), got_at(i), vecs[i].exp_level);
    got_q.delete();

    // stream error: reach prev=8, then an over-long exp-Golomb prefix
    pulse_start();
    send_word(32'b000010000, 9);
    for (int i = 0; i < 18; i++) send_bit(1'b0);
    idle();
    @(negedge clk) check("err_after_18_zeros", bus.err, 0);
    tick();
    send_bit(1'b0);
    idle();
    @(negedge clk) check("err_after_19_zeros", bus.err, 1);
    tick();
    send_word(32'b110, 3);
    idle();
    repeat (3) tick();
    check("err_levels_count", got_q.size(), 1);
    check("err_prior_level", got_at(0), 9);
    check("err_sticky", bus.err, 1);
    pulse_start();
    @(negedge clk) check("err_cleared_by_start", bus.err, 0);
    tick();
    got_q.delete();
    send_word(32'b10, 2);
    idle();
    wait_levels(1);
    check("err_recover_level", got_at(0), 1);
    got_q.delete();

    // backpressure across three codewords
    bus.level_ready = 1'b0;
    pulse_start();
    fork
      begin
        send_word(32'b10, 2);
        send_word(32'b11, 2);
        send_word(32'b010, 3);
        idle();
      end
      begin
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.level_valid && w < 50) begin
          w++;
          @(negedge clk);
        end
        check("bp_first_valid", bus.level_valid, 1);
        repeat (4) @(negedge clk);
        check("bp_bit_ready_low", bus.bit_ready, 0);
        check("bp_level_held", bus.level, 1);
        check("bp_nothing_taken", got_q.size(), 0);
        @(posedge clk) #1 bus.level_ready = 1'b1;
      end
    join
    wait_levels(3);
    check("bp_count", got_q.size(), 3);
    check("bp_order0", got_at(0), 1);
    check("bp_order1", got_at(1), -1);
    check("bp_order2", got_at(2), 2);
    got_q.delete();

    // asynchronous reset while in the exp-Golomb suffix
    pulse_start();
    send_word(32'b10, 2);
    send_word(32'b00010, 5);
    idle();
    #2 reset_n = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_level_valid", bus.level_valid, 0);
    check("arst_err", bus.err, 0);
    check("arst_bit_ready", bus.bit_ready, 1);
    @(posedge clk) #1 reset_n = 1'b1;
    got_q.delete();
    send_word(32'b00110, 5);
    idle();
    wait_levels(1);
    check("arst_next_level", got_at(0), 4);
    got_q.delete();

    // start outranks bit_valid: that bit must not be consumed
    bus.start = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b0;
    @(negedge clk) check("start_blocks_ready", bus.bit_ready, 0);
    @(posedge clk) #1 bus.start = 1'b0;
    send_word(32'b10, 2);
    idle();
    wait_levels(1);
    check("start_bit_not_consumed", got_at(0), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
